// File: rtl/fir_feed_pkg.sv
// Shared constants and types for the FIR sample feeder: FIR timing, FSM state
// encoding and the default sample type.
package fir_feed_pkg;

  localparam int FIR_TAPS   = 211;
  localparam int FIR_PERIOD = 2 * FIR_TAPS + 2;
  localparam int SAMPLE_W   = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } feed_state_t;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Back-to-back issue spacing when the FIFO never runs dry.
  function automatic int issue_spacing();
    return FIR_PERIOD + 2;
  endfunction

endpackage

// File: rtl/fir_feed_fifo.sv
// First-word-fall-through sample FIFO: the head is presented whenever the FIFO is
// non-empty, so a consumer can read and pop it on the same edge.
module fir_feed_fifo
  import fir_feed_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic signed [DATA_W-1:0]   wr_data_i,
  output logic signed [DATA_W-1:0]   head_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]            level_q, level_d;
  logic                     do_push, do_pop;

  // Flush wins over a same-cycle push; a same-cycle pop still hands out the head.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
    level_q <= LW'(DEPTH));

endmodule

// File: rtl/fir_sample_feeder.sv
// Feeds a ready/valid sample stream into the serial-MAC FIR one sample per FIR run.
// Optional watchdog in WAIT enabled by defining FIR_FEED_TIMEOUT_EN.
module fir_sample_feeder
  import fir_feed_pkg::*;
#(
  parameter int IN_WIDTH       = 16,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [IN_WIDTH-1:0]    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic signed [IN_WIDTH-1:0]    fir_data,
  output logic                          fir_valid,
  input  logic                          fir_done,
  input  logic                          flush,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          timeout_err
);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_CYCLES <= FIR_PERIOD + 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must exceed one full FIR run");
  end

  feed_state_t                 state_q, state_d;
  logic signed [IN_WIDTH-1:0]  fir_data_q, fir_data_d;
  logic                        fir_valid_q, fir_valid_d;
  logic                        timeout_err_q, timeout_err_d;
  logic signed [IN_WIDTH-1:0]  fifo_head;
  logic                        fifo_full, fifo_empty;
  logic                        pop;
  logic                        wd_expire;

  fir_feed_fifo #(
    .DATA_W (IN_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (s_valid),
    .pop_i     (pop),
    .flush_i   (flush),
    .wr_data_i (s_data),
    .head_o    (fifo_head),
    .level_o   (fifo_level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

`ifdef FIR_FEED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt_q, wd_cnt_d;

  // Counter sits at zero in IDLE, so every entry into WAIT starts from zero.
  assign wd_cnt_d  = (state_q == ST_WAIT) ? wd_cnt_q + 1'b1 : '0;
  assign wd_expire = (state_q == ST_WAIT) && (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    fir_data_d    = fir_data_q;
    fir_valid_d   = 1'b0;
    timeout_err_d = timeout_err_q;
    pop           = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          fir_data_d  = fifo_head;
          fir_valid_d = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A completion on the expiry edge beats the watchdog.
        if (fir_done) begin
          state_d = ST_IDLE;
        end else if (wd_expire) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      fir_data_q    <= '0;
      fir_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fir_data_q    <= fir_data_d;
      fir_valid_q   <= fir_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign s_ready     = !fifo_full;
  assign fir_data    = fir_data_q;
  assign fir_valid   = fir_valid_q;
  assign busy        = (state_q == ST_WAIT);
  assign timeout_err = timeout_err_q;

  a_single_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    fir_valid |=> !fir_valid);

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Randomised self-checking bench for fir_sample_feeder with a behavioural FIR in the loop.
module tb_fir_sample_feeder;
  import fir_feed_pkg::*;

  localparam int DEPTH    = 16;
  localparam int TMO      = 1024;
  localparam int DONE_LAT = FIR_PERIOD;
  localparam int SPACING  = FIR_PERIOD + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  sample_t    s_data;
  logic       s_valid, s_ready;
  sample_t    fir_data;
  logic       fir_valid, fir_done, flush;
  logic [4:0] fifo_level;
  logic       busy, timeout_err;

  logic model_done = 1'b0;
  logic man_done, fir_auto;
  int   model_cnt = 0;
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  int   ready_bad = 0;
  bit   saw_full = 0;
  sample_t iss_data[$];
  int      iss_cyc[$];

  assign fir_done = model_done | man_done;

  always #5 clk = ~clk;

  fir_sample_feeder #(
    .IN_WIDTH       (16),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .fir_data    (fir_data),
    .fir_valid   (fir_valid),
    .fir_done    (fir_done),
    .flush       (flush),
    .fifo_level  (fifo_level),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Issue recorder and ready-rule watcher.
  always @(negedge clk) begin
    if (fir_valid === 1'b1) begin
      iss_data.push_back(fir_data);
      iss_cyc.push_back(cyc);
    end
    if (fifo_level == 5'd16) saw_full <= 1'b1;
    if (s_ready !== (fifo_level != 5'd16)) ready_bad <= ready_bad + 1;
  end

  // FIR model: done pulses DONE_LAT cycles after it sees data_in_valid.
  always @(negedge clk) begin
    if (!fir_auto) begin
      model_cnt <= 0; model_done <= 1'b0;
    end else if (fir_valid === 1'b1) begin
      model_cnt <= DONE_LAT; model_done <= 1'b0;
    end else if (model_cnt > 1) begin
      model_cnt <= model_cnt - 1; model_done <= 1'b0;
    end else if (model_cnt == 1) begin
      model_cnt <= 0; model_done <= 1'b1;
    end else begin
      model_done <= 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  task automatic do_reset();
    fir_auto = 1'b0; man_done = 1'b0; s_valid = 1'b0; flush = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    iss_data.delete(); iss_cyc.delete();
  endtask

  task automatic push_one(input sample_t v, input int budget, output bit ok);
    ok = 0; s_data = v; s_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (s_ready === 1'b1) begin
        @(negedge clk); ok = 1; break;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_issues(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (iss_data.size() >= n) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) break;
      @(negedge clk);
    end
  endtask

  task automatic pulse_done();
    man_done = 1'b1; @(negedge clk); man_done = 1'b0;
  endtask

  task automatic test_reset();
    bit ok; bit bad;
    do_reset();
    for (int i = 0; i < 4; i++) push_one(sample_t'(i + 5), 10, ok);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_pre_busy: got %b want 1", busy); end
    n_cmp++; if (fifo_level !== 5'd3) begin n_bad++; $display("FAIL reset_pre_level: got %0d want 3", fifo_level); end
    rst_n = 1'b0; @(negedge clk);
    n_cmp++; if ({fir_valid, busy, timeout_err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {fir_valid, busy, timeout_err}); end
    n_cmp++; if (fir_data !== 16'sd0) begin n_bad++; $display("FAIL reset_data: got %0d want 0", fir_data); end
    n_cmp++; if (fifo_level !== 5'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", s_ready); end
    rst_n = 1'b1; pulse_done();
    bad = 0;
    repeat (4) begin
      if (fir_valid !== 1'b0 || busy !== 1'b0 || fifo_level !== 5'd0) bad = 1;
      @(negedge clk);
    end
    n_cmp++; if (bad) begin n_bad++; $display("FAIL reset_done_ignored: got activity after reset want none"); end
  endtask

  task automatic test_single();
    bit ok; sample_t v2;
    do_reset(); fir_auto = 1'b1;
    push_one(16'sh1234, 10, ok);
    n_cmp++; if (fir_valid !== 1'b0) begin n_bad++; $display("FAIL single_early: got fir_valid=%b want 0", fir_valid); end
    @(negedge clk);
    n_cmp++; if (fir_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", fir_valid); end
    n_cmp++; if (fir_data !== 16'sh1234) begin n_bad++; $display("FAIL single_data: got %h want 1234", fir_data); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
    @(negedge clk);
    n_cmp++; if (fir_valid !== 1'b0) begin n_bad++; $display("FAIL single_pulse_width: got %b want 0", fir_valid); end
    v2 = sample_t'($urandom);
    push_one(v2, 10, ok);
    wait_issues(2, SPACING + 50, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL single_second_issue: got %0d issues want 2", iss_data.size()); end
    else begin
      if (iss_data[1] !== v2 || iss_cyc[1] - iss_cyc[0] !== SPACING) begin
        n_bad++;
        $display("FAIL single_spacing: got data %h gap %0d want data %h gap %0d", iss_data[1], iss_cyc[1] - iss_cyc[0], v2, SPACING);
      end
    end
    wait_idle(SPACING + 50);
    @(negedge clk);
    n_cmp++; if (fir_data !== v2) begin n_bad++; $display("FAIL single_hold: got %h want %h", fir_data, v2); end
  endtask

  task automatic test_burst();
    bit ok;
    do_reset(); saw_full = 0; ready_bad = 0; fir_auto = 1'b1;
    for (int v = 1; v <= 20; v++) begin
      push_one(sample_t'(v), 1000, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL burst_push: sample %0d got not accepted want accepted", v); end
    end
    wait_issues(20, 20 * SPACING + 100, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL burst_count: got %0d want 20", iss_data.size()); end
    else begin
      for (int i = 0; i < 20; i++) begin
        n_cmp++;
        if (iss_data[i] !== sample_t'(i + 1) || (i > 0 && iss_cyc[i] - iss_cyc[i-1] < SPACING)) begin
          n_bad++;
          $display("FAIL burst_order[%0d]: got %0d gap %0d want %0d gap>=%0d", i, iss_data[i], (i > 0) ? iss_cyc[i] - iss_cyc[i-1] : 0, i + 1, SPACING);
        end
      end
    end
    n_cmp++; if (saw_full !== 1'b1) begin n_bad++; $display("FAIL burst_full: got level16 seen=%b want 1", saw_full); end
    n_cmp++; if (ready_bad !== 0) begin n_bad++; $display("FAIL burst_ready_rule: got %0d violations want 0", ready_bad); end
    wait_idle(SPACING + 50);
  endtask

  task automatic test_random();
    bit ok; sample_t expq[$]; sample_t v;
    do_reset(); fir_auto = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 700)) @(negedge clk);
      v = sample_t'($urandom);
      push_one(v, 1000, ok);
      expq.push_back(v);
    end
    wait_issues(10, 12 * SPACING, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL random_count: got %0d want 10", iss_data.size()); end
    else begin
      for (int i = 0; i < 10; i++) begin
        n_cmp++;
        if (iss_data[i] !== expq[i] || (i > 0 && iss_cyc[i] - iss_cyc[i-1] < SPACING)) begin
          n_bad++;
          $display("FAIL random_order[%0d]: got %h want %h", i, iss_data[i], expq[i]);
        end
      end
    end
    wait_idle(SPACING + 50);
  endtask

  task automatic test_flush();
    bit ok; bit bad; sample_t a;
    do_reset();
    for (int i = 0; i < 6; i++) push_one(sample_t'(100 + i), 10, ok);
    n_cmp++; if (fifo_level !== 5'd5 || busy !== 1'b1) begin n_bad++; $display("FAIL flush_pre: got level %0d busy %b want 5 1", fifo_level, busy); end
    flush = 1'b1; s_valid = 1'b1; s_data = 16'sd77;
    @(negedge clk);
    flush = 1'b0; s_valid = 1'b0;
    n_cmp++; if (fifo_level !== 5'd0) begin n_bad++; $display("FAIL flush_level: got %0d want 0", fifo_level); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy: got %b want 1", busy); end
    pulse_done();
    bad = 0;
    repeat (8) begin
      if (fir_valid !== 1'b0 || busy !== 1'b0) bad = 1;
      @(negedge clk);
    end
    n_cmp++; if (bad || iss_data.size() != 1) begin n_bad++; $display("FAIL flush_no_issue: got %0d issues want 1", iss_data.size()); end
    a = sample_t'($urandom);
    push_one(a, 10, ok);
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    n_cmp++;
    if (fir_valid !== 1'b1 || fir_data !== a || fifo_level !== 5'd0) begin
      n_bad++;
      $display("FAIL flush_with_pop: got valid %b data %h level %0d want 1 %h 0", fir_valid, fir_data, fifo_level, a);
    end
    pulse_done();
  endtask

  task automatic test_stray();
    bit ok; bit bad; sample_t v;
    do_reset();
    pulse_done();
    bad = 0;
    repeat (3) begin
      if (fir_valid !== 1'b0 || busy !== 1'b0 || fifo_level !== 5'd0 || timeout_err !== 1'b0) bad = 1;
      @(negedge clk);
    end
    n_cmp++; if (bad) begin n_bad++; $display("FAIL stray_done: got activity want none"); end
    v = sample_t'($urandom);
    push_one(v, 10, ok);
    @(negedge clk);
    n_cmp++; if (fir_valid !== 1'b1 || fir_data !== v) begin n_bad++; $display("FAIL stray_still_idle: got valid %b data %h want 1 %h", fir_valid, fir_data, v); end
  endtask

  task automatic test_timeout();
    bit ok; sample_t a, b;
    do_reset();
    a = sample_t'($urandom); b = sample_t'($urandom);
    push_one(a, 10, ok);
    push_one(b, 10, ok);
`ifdef FIR_FEED_TIMEOUT_EN
    begin
      int at;
      at = -1;
      for (int i = 0; i < TMO + 80; i++) begin
        if (timeout_err === 1'b1) begin at = cyc; break; end
        @(negedge clk);
      end
      n_cmp++; if (at < 0 || at - iss_cyc[0] !== TMO) begin n_bad++; $display("FAIL timeout_time: got %0d want %0d", at - iss_cyc[0], TMO); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout_idle: got busy %b want 0", busy); end
      wait_issues(2, 10, ok);
      n_cmp++; if (!ok || iss_data[1] !== b || iss_cyc[1] - iss_cyc[0] !== TMO + 1) begin n_bad++; $display("FAIL timeout_next: got %0d issues want 2 with data %h", iss_data.size(), b); end
      pulse_done(); repeat (3) @(negedge clk);
      n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got %b want 1", timeout_err); end
    end
`else
    repeat (TMO + 76) @(negedge clk);
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL timeout_off_err: got %b want 0", timeout_err); end
    n_cmp++; if (busy !== 1'b1 || iss_data.size() != 1) begin n_bad++; $display("FAIL timeout_off_busy: got busy %b issues %0d want 1 1", busy, iss_data.size()); end
    pulse_done();
    wait_issues(2, 10, ok);
    n_cmp++; if (!ok || iss_data[1] !== b) begin n_bad++; $display("FAIL timeout_off_next: got %0d issues want 2 with data %h", iss_data.size(), b); end
`endif
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; flush = 1'b0; man_done = 1'b0; fir_auto = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_burst();
    test_random();
    test_flush();
    test_stray();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
